jtframe_ioctl_upload: RTL

SPI-slave transmitter for the MiST I/O link. When the ARM controller opens a frame on `SPI_SS2` and issues the upload command, the block reads bytes from game memory through an `ioctl`-style read port and serialises them MSB-first on `SPI_DO`. Typical uses are NVRAM and high-score save. It is the opposite direction to the ROM-download path (`ioctl_addr`/`ioctl_data`/`ioctl_wr`) and sits beside it in the MiST base. All SPI inputs are oversampled in `clk_sys`; there is no second clock domain.

---
 rtl/jtframe_ioctl_upload_if.sv | 38 +++
 rtl/jtframe_ioctl_upload.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/jtframe_ioctl_upload_if.sv
//----------------------------------------------------------------------------
// jtframe_ioctl_upload_if
//
// Bundles the SPI pins of the MiST I/O link together with the ioctl-style
// read port used by the upload block.
//   SPI_SCK, SPI_SS2, SPI_DI : SPI clock, frame select (active low), data in
//   spi_do, spi_do_oe        : SPI data out and its tri-state enable
//   ioctl_addr, ioctl_rd     : byte address and one-cycle read strobe
//   ioctl_data2sd            : read data returned by game memory
//   upload_busy              : upload in progress
// The slave modport is the upload block; the master modport is the
// ARM controller plus the game memory.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

interface jtframe_ioctl_upload_if #(
    parameter int AW = 25
);
    logic          SPI_SCK;
    logic          SPI_SS2;
    logic          SPI_DI;
    logic          spi_do;
    logic          spi_do_oe;
    logic [AW-1:0] ioctl_addr;
    logic          ioctl_rd;
    logic [7:0]    ioctl_data2sd;
    logic          upload_busy;

    modport slave (
        input  SPI_SCK, SPI_SS2, SPI_DI, ioctl_data2sd,
        output spi_do, spi_do_oe, ioctl_addr, ioctl_rd, upload_busy
    );

    modport master (
        output SPI_SCK, SPI_SS2, SPI_DI, ioctl_data2sd,
        input  spi_do, spi_do_oe, ioctl_addr, ioctl_rd, upload_busy
    );
endinterface

// File: rtl/jtframe_ioctl_upload.sv
//----------------------------------------------------------------------------
// jtframe_ioctl_upload
//
// SPI-slave transmitter for the MiST I/O link. After SPI_SS2 falls and the
// ARM sends CMD_UPLOAD, bytes are fetched from game memory through the
// ioctl read port and shifted out MSB-first on spi_do (SPI mode 0).
//
// Ports:
//   clk_sys : system clock, the only clock; SPI pins are oversampled
//   rst_n   : asynchronous active-low reset
//   bus     : jtframe_ioctl_upload_if.slave (SPI pins + ioctl read port)
//
// Parameters:
//   AW         : ioctl_addr width (must match the interface AW)
//   CMD_UPLOAD : command byte that starts an upload
//   RD_LAT     : cycles from ioctl_rd to valid ioctl_data2sd (>= 1)
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module jtframe_ioctl_upload #(
    parameter int         AW         = 25,
    parameter logic [7:0] CMD_UPLOAD = 8'h54,
    parameter int         RD_LAT     = 2
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    jtframe_ioctl_upload_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_SEND,
        ST_IGNORE
    } state_t;

    localparam int          LW       = $clog2(RD_LAT + 2);
    // Counter starts one above RD_LAT so that the value 1 marks the cycle
    // in which ioctl_data2sd is valid.
    localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT + 1);

    // Synchroniser chains: _m first stage, _s synchronised, _h history
    logic sck_m_q, sck_s_q, sck_h_q;
    logic ss_m_q,  ss_s_q,  ss_h_q;
    logic di_m_q,  di_s_q;
    logic sck_rise_q, sck_fall_q, ss_fall_q, ss_rise_q;

    state_t        state_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic [7:0]    buf_q;
    logic [LW-1:0] lat_q;
    logic [AW-1:0] addr_q;
    logic          rd_q;
    logic          busy_q;
    logic          do_q;
    logic          oe_q;

    logic [7:0]    cmd_d;
    logic [AW-1:0] addr_d;

    assign cmd_d  = {sh_q[6:0], di_s_q};
    assign addr_d = addr_q + 1'b1;   // wraps modulo 2^AW

    assign bus.spi_do      = do_q;
    assign bus.spi_do_oe   = oe_q;
    assign bus.ioctl_addr  = addr_q;
    assign bus.ioctl_rd    = rd_q;
    assign bus.upload_busy = busy_q;

    // Two-flop synchronisers plus a history flop; edge strobes are
    // registered, giving three cycles from pin edge to strobe.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sck_m_q    <= 1'b0;
            sck_s_q    <= 1'b0;
            sck_h_q    <= 1'b0;
            ss_m_q     <= 1'b1;
            ss_s_q     <= 1'b1;
            ss_h_q     <= 1'b1;
            di_m_q     <= 1'b0;
            di_s_q     <= 1'b0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            ss_fall_q  <= 1'b0;
            ss_rise_q  <= 1'b0;
        end else begin
            sck_m_q    <= bus.SPI_SCK;
            sck_s_q    <= sck_m_q;
            sck_h_q    <= sck_s_q;
            ss_m_q     <= bus.SPI_SS2;
            ss_s_q     <= ss_m_q;
            ss_h_q     <= ss_s_q;
            di_m_q     <= bus.SPI_DI;
            di_s_q     <= di_m_q;
            sck_rise_q <=  sck_s_q & ~sck_h_q;
            sck_fall_q <= ~sck_s_q &  sck_h_q;
            ss_fall_q  <= ~ss_s_q  &  ss_h_q;
            ss_rise_q  <=  ss_s_q  & ~ss_h_q;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            buf_q   <= 8'd0;
            lat_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            do_q    <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            rd_q <= 1'b0;
            // The read latency counter keeps running across an abort so an
            // in-flight read completes; its data is simply not captured.
            if (lat_q != '0) lat_q <= lat_q - 1'b1;

            if (ss_rise_q) begin
                // Frame end wins over any SCK strobe in the same cycle
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                oe_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ss_fall_q) begin
                            state_q <= ST_CMD;
                            bit_q   <= 3'd0;
                            sh_q    <= 8'd0;
                            addr_q  <= '0;
                        end
                    end

                    ST_CMD: begin
                        if (sck_rise_q) begin
                            sh_q  <= cmd_d;
                            bit_q <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                if (cmd_d == CMD_UPLOAD) begin
                                    state_q <= ST_FETCH;
                                    busy_q  <= 1'b1;
                                    rd_q    <= 1'b1;
                                    lat_q   <= LAT_INIT;
                                    oe_q    <= ~ss_m_q;
                                end else begin
                                    state_q <= ST_IGNORE;
                                end
                            end
                        end
                    end

                    ST_FETCH: begin
                        // ss_m_q is what ss_s_q becomes this edge, so oe
                        // follows the synchronised SS without a lag.
                        oe_q <= ~ss_m_q;
                        if (lat_q == 1) begin
                            buf_q   <= bus.ioctl_data2sd;
                            bit_q   <= 3'd0;
                            state_q <= ST_SEND;
                        end
                    end

                    ST_SEND: begin
                        oe_q <= ~ss_m_q;
                        if (lat_q == 1) buf_q <= bus.ioctl_data2sd;
                        if (sck_fall_q) begin
                            // bit_q counts falls within a byte; fall 0 is the
                            // one following the previous byte's last rise.
                            if (bit_q == 3'd0) begin
                                do_q   <= buf_q[7];
                                sh_q   <= {buf_q[6:0], 1'b0};
                                addr_q <= addr_d;
                                rd_q   <= 1'b1;
                                lat_q  <= LAT_INIT;
                            end else begin
                                do_q <= sh_q[7];
                                sh_q <= {sh_q[6:0], 1'b0};
                            end
                            bit_q <= bit_q + 3'd1;
                        end
                    end

                    ST_IGNORE: begin
                        oe_q <= 1'b0;
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
